// File: rtl/eth_mdio_ctrl_if.sv
// Command/response channel of the MDIO management master.
interface eth_mdio_ctrl_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_read;
    logic [4:0]  cmd_phyad;
    logic [4:0]  cmd_regad;
    logic [15:0] cmd_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output cmd_valid, cmd_read, cmd_phyad, cmd_regad, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_read, cmd_phyad, cmd_regad, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/eth_mdio_ctrl.sv
// Clause-22 MDIO master: serialises one read/write management frame per
// accepted command and returns read data with a one-cycle response strobe.
module eth_mdio_ctrl #(
    parameter int unsigned CLK_DIV     = 13,
    parameter bit          PREAMBLE_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rstn,
    eth_mdio_ctrl_if.slave       bus,
    output logic                 mdc,
    output logic                 mdio_o,
    output logic                 mdio_t,
    input  logic                 mdio_i
);
    localparam int unsigned FRAME_W = PREAMBLE_EN ? 64 : 32;
    localparam int unsigned HCNT_W  = 8;
    localparam int unsigned BCNT_W  = 7;
    localparam logic [HCNT_W-1:0] HALF_LAST = HCNT_W'(CLK_DIV - 1);
    localparam logic [BCNT_W-1:0] BITS      = BCNT_W'(FRAME_W);
    // r_bit counts bits already started: first TA bit index, TA2 and DATA sample points
    localparam logic [BCNT_W-1:0] TA_POS    = BCNT_W'(FRAME_W - 18);
    localparam logic [BCNT_W-1:0] ERR_BIT   = BCNT_W'(FRAME_W - 16);
    localparam logic [BCNT_W-1:0] DATA_BIT  = BCNT_W'(FRAME_W - 15);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t              r_state;
    logic [FRAME_W-1:0]  r_frame;
    logic [HCNT_W-1:0]   r_hcnt;
    logic [BCNT_W-1:0]   r_bit;
    logic                r_high;
    logic                r_read;
    logic                r_err_sh;
    logic [15:0]         r_rd_sh;
    logic                r_ready;
    logic                r_rsp_valid;
    logic                r_err;
    logic [15:0]         r_rdata;
    logic                r_mdc;
    logic                r_mdo;
    logic                r_mdt;

    logic [31:0]         w_frame32;
    logic [FRAME_W-1:0]  w_frame;

    assign w_frame32 = {2'b01,
                        bus.cmd_read ? 2'b10 : 2'b01,
                        bus.cmd_phyad,
                        bus.cmd_regad,
                        bus.cmd_read ? 2'b11 : 2'b10,
                        bus.cmd_read ? 16'hFFFF : bus.cmd_wdata};
    assign w_frame   = FRAME_W'({32'hFFFF_FFFF, w_frame32});

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_frame     <= '0;
            r_hcnt      <= '0;
            r_bit       <= '0;
            r_high      <= 1'b0;
            r_read      <= 1'b0;
            r_err_sh    <= 1'b0;
            r_rd_sh     <= '0;
            r_ready     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_err       <= 1'b0;
            r_rdata     <= '0;
            r_mdc       <= 1'b0;
            r_mdo       <= 1'b1;
            r_mdt       <= 1'b1;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_ready <= 1'b1;
                    // Bit 0 low phase starts on the accepting edge itself
                    if (bus.cmd_valid && r_ready) begin
                        r_ready <= 1'b0;
                        r_state <= S_SHIFT;
                        r_read  <= bus.cmd_read;
                        r_frame <= w_frame << 1;
                        r_mdo   <= w_frame[FRAME_W-1];
                        r_mdt   <= 1'b0;
                        r_mdc   <= 1'b0;
                        r_hcnt  <= HALF_LAST;
                        r_high  <= 1'b0;
                        r_bit   <= BCNT_W'(1);
                    end
                end
                S_SHIFT: begin
                    if (r_hcnt != '0) begin
                        r_hcnt <= r_hcnt - HCNT_W'(1);
                    end else if (!r_high) begin
                        r_high <= 1'b1;
                        r_mdc  <= 1'b1;
                        r_hcnt <= HALF_LAST;
                        if (r_read && r_bit == ERR_BIT) begin
                            r_err_sh <= mdio_i;
                        end
                        if (r_read && r_bit >= DATA_BIT) begin
                            r_rd_sh <= {r_rd_sh[14:0], mdio_i};
                        end
                    end else if (r_bit == BITS) begin
                        r_state     <= S_DONE;
                        r_rsp_valid <= 1'b1;
                        r_mdc       <= 1'b0;
                        r_mdo       <= 1'b1;
                        r_mdt       <= 1'b1;
                        if (r_read) begin
                            r_rdata <= r_rd_sh;
                            r_err   <= r_err_sh;
                        end else begin
                            r_err   <= 1'b0;
                        end
                    end else begin
                        // Reads hand the line to the PHY from the first TA bit on
                        r_high  <= 1'b0;
                        r_mdc   <= 1'b0;
                        r_hcnt  <= HALF_LAST;
                        r_mdo   <= r_frame[FRAME_W-1];
                        r_frame <= r_frame << 1;
                        r_mdt   <= r_read && (r_bit >= TA_POS);
                        r_bit   <= r_bit + BCNT_W'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready = r_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_err   = r_err;
    assign mdc           = r_mdc;
    assign mdio_o        = r_mdo;
    assign mdio_t        = r_mdt;
endmodule

// File: tb/tb_eth_mdio_ctrl.sv
// Bench for eth_mdio_ctrl: two instances (preamble/CLK_DIV=2 and no preamble/CLK_DIV=1)
// checked against a frame-level reference model with a behavioural PHY.
module tb_eth_mdio_ctrl;
    localparam int NI    = 2;
    localparam int LIMIT = 2000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    logic [NI-1:0]        rstn;
    logic [NI-1:0]        c_valid, c_read;
    logic [NI-1:0][4:0]   c_phy, c_reg;
    logic [NI-1:0][15:0]  c_wdata;
    logic [NI-1:0][63:0]  phy_pat;

    logic [NI-1:0]        o_ready, o_rv, o_err, o_mdc, o_mdo, o_mdt;
    logic [NI-1:0][15:0]  o_rdata;
    logic [NI-1:0][63:0]  m_dat, m_tri;
    logic [NI-1:0][31:0]  m_n, m_rsp;
    logic [NI-1:0]        m_perr;

    logic [15:0]          mem [32][32];
    logic [NI-1:0][15:0]  exp_rdata;
    int                   last_acc, last_rsp;

    for (genvar g = 0; g < NI; g++) begin : gi
        localparam int unsigned D = (g == 0) ? 2 : 1;
        localparam bit          P = (g == 0);
        localparam int          B = P ? 64 : 32;

        eth_mdio_ctrl_if bus();
        logic mdc, mdio_o, mdio_t, mdio_i;

        eth_mdio_ctrl #(.CLK_DIV(D), .PREAMBLE_EN(P)) dut (
            .clk(clk), .rstn(rstn[g]), .bus(bus),
            .mdc(mdc), .mdio_o(mdio_o), .mdio_t(mdio_t), .mdio_i(mdio_i)
        );

        assign bus.cmd_valid = c_valid[g];
        assign bus.cmd_read  = c_read[g];
        assign bus.cmd_phyad = c_phy[g];
        assign bus.cmd_regad = c_reg[g];
        assign bus.cmd_wdata = c_wdata[g];
        assign o_ready[g] = bus.cmd_ready;
        assign o_rv[g]    = bus.rsp_valid;
        assign o_err[g]   = bus.rsp_err;
        assign o_rdata[g] = bus.rsp_rdata;
        assign o_mdc[g]   = mdc;
        assign o_mdo[g]   = mdio_o;
        assign o_mdt[g]   = mdio_t;

        logic [63:0] dat = '0, triv = '0;
        int n = 0, rsp = 0, last_rise = 0;
        logic perr = 1'b0, prev_mdc = 1'b0;

        // PHY reply: bit n of the frame (MSB first) while n bits have been clocked
        assign mdio_i = (n < B) ? phy_pat[g][B-1-n] : 1'b1;

        // Frame capture on each MDC rise, restarted at every accepted command
        always @(posedge clk) begin
            prev_mdc <= mdc;
            if (bus.cmd_valid && bus.cmd_ready) begin
                dat <= '0; triv <= '0; n <= 0; perr <= 1'b0;
            end else if (mdc && !prev_mdc) begin
                dat  <= {dat[62:0], mdio_o};
                triv <= {triv[62:0], mdio_t};
                n    <= n + 1;
                if (n > 0 && (cyc - last_rise) != int'(2 * D)) perr <= 1'b1;
                last_rise <= cyc;
            end
            if (bus.rsp_valid) rsp <= rsp + 1;
        end

        assign m_dat[g]  = dat;
        assign m_tri[g]  = triv;
        assign m_n[g]    = 32'(n);
        assign m_rsp[g]  = 32'(rsp);
        assign m_perr[g] = perr;
    end

    function automatic int bits_of(input int w);
        return (w == 0) ? 64 : 32;
    endfunction

    function automatic int div_of(input int w);
        return (w == 0) ? 2 : 1;
    endfunction

    // One full command: drive, await accept, scramble inputs, await response, check
    task automatic issue(input int w, input bit rd, input logic [4:0] pa, input logic [4:0] ra,
                         input logic [15:0] wd, input bit hold);
        int B, D, n, acc, at;
        bit present;
        logic [63:0] full, mask, omask, tmask;
        logic [15:0] rdv, exp_rd;
        logic exp_err;
        B = bits_of(w);
        D = div_of(w);
        present = (pa == 5'd3) || (pa == 5'd7);
        rdv = present ? mem[pa][ra] : 16'hFFFF;
        full = {32'hFFFF_FFFF, 2'b01, rd ? 2'b10 : 2'b01, pa, ra, 2'b10, wd};
        mask = (B == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        tmask = rd ? 64'h0000_0000_0003_FFFF : 64'h0;
        omask = rd ? (mask & ~64'h0000_0000_0003_FFFF) : mask;
        exp_err = rd ? !present : 1'b0;
        exp_rd  = rd ? rdv : exp_rdata[w];
        phy_pat[w] = {{46{1'b1}}, 1'b1, !present, rdv};

        c_read[w] = rd; c_phy[w] = pa; c_reg[w] = ra; c_wdata[w] = wd; c_valid[w] = 1'b1;
        n = 0;
        while (!o_ready[w] && n < LIMIT) begin @(negedge clk); n++; end
        if (!o_ready[w]) begin
            n_vec++; n_err++;
            $display("FAIL accept_timeout w=%0d ready=%0b after %0d cycles", w, o_ready[w], n);
            c_valid[w] = 1'b0;
            return;
        end
        acc = cyc + 1;
        last_acc = acc;
        @(negedge clk);
        c_read[w] = 1'($urandom); c_phy[w] = 5'($urandom); c_reg[w] = 5'($urandom);
        c_wdata[w] = 16'($urandom);
        if (!hold) c_valid[w] = 1'b0;

        n = 0;
        while (!o_rv[w] && n < 2 * D * B + 8) begin @(negedge clk); n++; end
        at = cyc;
        last_rsp = at;
        if (rd) exp_rdata[w] = rdv;
        else if (present) mem[pa][ra] = wd;

        n_vec++;
        if (!o_rv[w] || (at - acc) != 2 * D * B) begin
            n_err++;
            $display("FAIL rsp_latency w=%0d rv=%0b got=%0d exp=%0d", w, o_rv[w], at - acc, 2 * D * B);
        end
        n_vec++;
        if (o_err[w] !== exp_err) begin
            n_err++;
            $display("FAIL rsp_err w=%0d rd=%0b pa=%0d got=%0b exp=%0b", w, rd, pa, o_err[w], exp_err);
        end
        n_vec++;
        if (o_rdata[w] !== exp_rd) begin
            n_err++;
            $display("FAIL rsp_rdata w=%0d rd=%0b pa=%0d ra=%0d got=%h exp=%h", w, rd, pa, ra, o_rdata[w], exp_rd);
        end
        n_vec++;
        if (int'(m_n[w]) != B) begin
            n_err++;
            $display("FAIL bit_count w=%0d got=%0d exp=%0d", w, m_n[w], B);
        end
        n_vec++;
        if ((m_dat[w] & omask) !== (full & omask)) begin
            n_err++;
            $display("FAIL frame_data w=%0d got=%h exp=%h", w, m_dat[w] & omask, full & omask);
        end
        n_vec++;
        if ((m_tri[w] & mask) !== tmask) begin
            n_err++;
            $display("FAIL frame_tristate w=%0d got=%h exp=%h", w, m_tri[w] & mask, tmask);
        end
        n_vec++;
        if (m_perr[w] !== 1'b0) begin
            n_err++;
            $display("FAIL mdc_period w=%0d got=irregular exp=%0d cycles", w, 2 * D);
        end
        @(negedge clk);
        n_vec++;
        if (o_rv[w] !== 1'b0 || o_ready[w] !== 1'b1 || o_mdc[w] !== 1'b0 || o_mdt[w] !== 1'b1) begin
            n_err++;
            $display("FAIL after_done w=%0d got rv=%0b ready=%0b mdc=%0b mdt=%0b exp 0 1 0 1",
                     w, o_rv[w], o_ready[w], o_mdc[w], o_mdt[w]);
        end
    endtask

    task automatic test_reset();
        c_valid = '0; c_read = '0; c_phy = '0; c_reg = '0; c_wdata = '0;
        phy_pat = '1; exp_rdata = '0;
        rstn = '1;
        #1 rstn = '0;
        #11;
        for (int w = 0; w < NI; w++) begin
            n_vec++;
            if ({o_ready[w], o_rv[w], o_err[w], o_mdc[w], o_mdo[w], o_mdt[w], o_rdata[w]} !== {6'b000011, 16'h0}) begin
                n_err++;
                $display("FAIL reset_values w=%0d got rdy=%0b rv=%0b err=%0b mdc=%0b mdo=%0b mdt=%0b rd=%h exp 0 0 0 0 1 1 0000",
                         w, o_ready[w], o_rv[w], o_err[w], o_mdc[w], o_mdo[w], o_mdt[w], o_rdata[w]);
            end
        end
        @(negedge clk);
        rstn = '1;
        @(negedge clk);
        for (int w = 0; w < NI; w++) begin
            n_vec++;
            if (o_ready[w] !== 1'b1) begin
                n_err++;
                $display("FAIL ready_after_reset w=%0d got=%0b exp=1", w, o_ready[w]);
            end
        end
    endtask

    task automatic test_write();
        issue(0, 1'b0, 5'd1, 5'd0, 16'h1140, 1'b0);
    endtask

    task automatic test_read();
        mem[3][2] = 16'hABCD;
        issue(0, 1'b1, 5'd3, 5'd2, 16'h0, 1'b0);
        issue(0, 1'b0, 5'd3, 5'd4, 16'($urandom), 1'b0);
        n_vec++;
        if (o_rdata[0] !== 16'hABCD) begin
            n_err++;
            $display("FAIL rdata_hold got=%h exp=abcd", o_rdata[0]);
        end
    endtask

    task automatic test_absent();
        issue(0, 1'b1, 5'd9, 5'd1, 16'h0, 1'b0);
        n_vec++;
        if (o_err[0] !== 1'b1 || o_rdata[0] !== 16'hFFFF) begin
            n_err++;
            $display("FAIL absent_phy got err=%0b rdata=%h exp err=1 rdata=ffff", o_err[0], o_rdata[0]);
        end
    endtask

    task automatic test_back_to_back();
        int acc1, rsp1;
        issue(0, 1'b1, 5'd3, 5'd2, 16'h0, 1'b1);
        acc1 = last_acc;
        rsp1 = last_rsp;
        issue(0, 1'b0, 5'd7, 5'd1, 16'($urandom), 1'b0);
        n_vec++;
        if (last_acc - rsp1 != 2) begin
            n_err++;
            $display("FAIL b2b_accept_gap got=%0d exp=2 edges after rsp_valid", last_acc - rsp1);
        end
        n_vec++;
        if (last_acc - acc1 != 2 * 2 * 64 + 2) begin
            n_err++;
            $display("FAIL b2b_issue_rate got=%0d exp=%0d", last_acc - acc1, 2 * 2 * 64 + 2);
        end
    endtask

    task automatic test_reset_mid();
        int n, rcnt;
        c_read[0] = 1'b0; c_phy[0] = 5'd3; c_reg[0] = 5'd5; c_wdata[0] = 16'($urandom);
        c_valid[0] = 1'b1;
        n = 0;
        while (!o_ready[0] && n < LIMIT) begin @(negedge clk); n++; end
        @(negedge clk);
        c_valid[0] = 1'b0;
        n = 0;
        while (int'(m_n[0]) < 40 && n < LIMIT) begin @(negedge clk); n++; end
        n_vec++;
        if (int'(m_n[0]) != 40) begin
            n_err++;
            $display("FAIL midframe_reach got=%0d exp=40", m_n[0]);
        end
        rcnt = int'(m_rsp[0]);
        #2 rstn[0] = 1'b0;
        exp_rdata[0] = 16'h0;
        #1;
        n_vec++;
        if ({o_ready[0], o_rv[0], o_err[0], o_mdc[0], o_mdo[0], o_mdt[0], o_rdata[0]} !== {6'b000011, 16'h0}) begin
            n_err++;
            $display("FAIL async_abort got rdy=%0b rv=%0b err=%0b mdc=%0b mdo=%0b mdt=%0b rd=%h exp 0 0 0 0 1 1 0000",
                     o_ready[0], o_rv[0], o_err[0], o_mdc[0], o_mdo[0], o_mdt[0], o_rdata[0]);
        end
        repeat (3) @(negedge clk);
        rstn[0] = 1'b1;
        repeat (2 * 2 * 64 + 10) @(negedge clk);
        n_vec++;
        if (int'(m_rsp[0]) != rcnt || o_mdc[0] !== 1'b0 || o_mdt[0] !== 1'b1) begin
            n_err++;
            $display("FAIL abort_no_rsp got rsp=%0d mdc=%0b mdt=%0b exp rsp=%0d mdc=0 mdt=1",
                     m_rsp[0], o_mdc[0], o_mdt[0], rcnt);
        end
        issue(0, 1'b0, 5'd7, 5'd3, 16'($urandom), 1'b0);
    endtask

    task automatic test_nopreamble();
        issue(1, 1'b0, 5'd1, 5'd0, 16'h1140, 1'b0);
        issue(1, 1'b1, 5'd3, 5'd2, 16'h0, 1'b0);
        issue(1, 1'b1, 5'd30, 5'd31, 16'h0, 1'b0);
    endtask

    task automatic test_random();
        logic [4:0] pa;
        for (int w = 0; w < NI; w++) begin
            for (int i = 0; i < 14; i++) begin
                case ($urandom_range(0, 2))
                    0: pa = 5'd3;
                    1: pa = 5'd7;
                    default: pa = 5'($urandom);
                endcase
                issue(w, 1'($urandom), pa, 5'($urandom), 16'($urandom), (i != 13) && 1'($urandom));
            end
        end
    endtask

    initial begin
        for (int p = 0; p < 32; p++)
            for (int r = 0; r < 32; r++)
                mem[p][r] = 16'($urandom);
        last_acc = 0;
        last_rsp = 0;
        test_reset();
        test_write();
        test_read();
        test_absent();
        test_back_to_back();
        test_reset_mid();
        test_nopreamble();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time=%0t exp=finish earlier", $time);
        $fatal(1);
    end
endmodule
